// File: rtl/tile_solver_dispatcher.sv
// Purpose: shares one host packet stream and one result stream across NUM_SOLVERS solvers, round-robin both ways.
// Latency: input words pass through combinationally once a solver is selected (one select cycle per packet); results appear one cycle after a solver raises valid.
// Backpressure: in_ready follows the selected solver's ready; out_ready is routed to the locked solver only, all other lanes held off.
module tile_solver_dispatcher #(
    parameter int NUM_SOLVERS = 4,
    parameter int SEL_BITS    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_end_of_stream,
    output logic [31:0]               out_addr,
    output logic [15:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               slv_in_data,
    output logic [NUM_SOLVERS-1:0]    slv_in_valid,
    input  logic [NUM_SOLVERS-1:0]    slv_in_ready,
    output logic [NUM_SOLVERS-1:0]    slv_in_end_of_stream,
    input  logic [32*NUM_SOLVERS-1:0] slv_out_addr,
    input  logic [16*NUM_SOLVERS-1:0] slv_out_data,
    input  logic [NUM_SOLVERS-1:0]    slv_out_valid,
    output logic [NUM_SOLVERS-1:0]    slv_out_ready,
    output logic [NUM_SOLVERS-1:0]    busy,
    output logic [15:0]               dispatched_count,
    output logic [15:0]               completed_count
);

    typedef enum logic {IN_SELECT, IN_FORWARD} in_state_t;

    in_state_t               in_state, in_state_nxt;
    logic [SEL_BITS-1:0]     in_sel, in_sel_nxt, in_rr, in_rr_nxt;
    logic [SEL_BITS-1:0]     out_sel, out_sel_nxt, out_rr, out_rr_nxt;
    logic                    out_locked, out_locked_nxt;
    logic [NUM_SOLVERS-1:0]  busy_q, busy_nxt;
    logic [15:0]             disp_q, disp_nxt, comp_q, comp_nxt;

    logic                    idle_found, rslt_found;
    logic [SEL_BITS-1:0]     idle_idx, rslt_idx;

    // Solver index base+k, wrapped at NUM_SOLVERS (not at 2**SEL_BITS).
    function automatic logic [SEL_BITS-1:0] wrap_add(input logic [SEL_BITS-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SOLVERS) s = s - NUM_SOLVERS;
        return SEL_BITS'(s);
    endfunction

    // Round-robin scans: first idle solver from in_rr, first pending result from out_rr.
    always_comb begin
        idle_found = 1'b0;
        idle_idx   = '0;
        rslt_found = 1'b0;
        rslt_idx   = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            if (!idle_found && !busy_q[wrap_add(in_rr, k)]) begin
                idle_found = 1'b1;
                idle_idx   = wrap_add(in_rr, k);
            end
            if (!rslt_found && slv_out_valid[wrap_add(out_rr, k)]) begin
                rslt_found = 1'b1;
                rslt_idx   = wrap_add(out_rr, k);
            end
        end
    end

    // Next-state and lane steering for the input FSM and the output arbiter.
    always_comb begin
        in_state_nxt         = in_state;
        in_sel_nxt           = in_sel;
        in_rr_nxt            = in_rr;
        out_sel_nxt          = out_sel;
        out_rr_nxt           = out_rr;
        out_locked_nxt       = out_locked;
        busy_nxt             = busy_q;
        disp_nxt             = disp_q;
        comp_nxt             = comp_q;
        in_ready             = 1'b0;
        slv_in_data          = in_data;
        slv_in_valid         = '0;
        slv_in_end_of_stream = '0;
        out_addr             = '0;
        out_data             = '0;
        out_valid            = 1'b0;
        slv_out_ready        = '0;

        case (in_state)
            IN_SELECT: begin
                if (idle_found) begin
                    in_sel_nxt   = idle_idx;
                    in_state_nxt = IN_FORWARD;
                end
            end
            IN_FORWARD: begin
                in_ready                     = slv_in_ready[in_sel];
                slv_in_valid[in_sel]         = in_valid;
                slv_in_end_of_stream[in_sel] = in_end_of_stream & in_valid;
                if (in_valid && slv_in_ready[in_sel] && in_end_of_stream) begin
                    busy_nxt[in_sel] = 1'b1;
                    in_rr_nxt        = wrap_add(in_sel, 1);
                    disp_nxt         = disp_q + 16'd1;
                    in_state_nxt     = IN_SELECT;
                end
            end
            default: in_state_nxt = IN_SELECT;
        endcase

        if (out_locked) begin
            out_addr               = slv_out_addr[32*int'(out_sel) +: 32];
            out_data               = slv_out_data[16*int'(out_sel) +: 16];
            out_valid              = slv_out_valid[out_sel];
            slv_out_ready[out_sel] = out_ready;
            if (!slv_out_valid[out_sel]) begin
                // Solver withdrew its result: release without side effects.
                out_locked_nxt = 1'b0;
            end else if (out_ready) begin
                busy_nxt[out_sel] = 1'b0;
                comp_nxt          = comp_q + 16'd1;
                out_rr_nxt        = wrap_add(out_sel, 1);
                out_locked_nxt    = 1'b0;
            end
        end else if (rslt_found) begin
            out_sel_nxt    = rslt_idx;
            out_locked_nxt = 1'b1;
        end

        // Outputs are forced quiet while reset is held, even on the first reset cycle.
        if (reset) begin
            in_ready             = 1'b0;
            slv_in_data          = '0;
            slv_in_valid         = '0;
            slv_in_end_of_stream = '0;
            out_addr             = '0;
            out_data             = '0;
            out_valid            = 1'b0;
            slv_out_ready        = '0;
        end
    end

    assign busy             = reset ? '0 : busy_q;
    assign dispatched_count = reset ? '0 : disp_q;
    assign completed_count  = reset ? '0 : comp_q;

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_state   <= IN_SELECT;
            in_sel     <= '0;
            in_rr      <= '0;
            out_sel    <= '0;
            out_rr     <= '0;
            out_locked <= 1'b0;
            busy_q     <= '0;
            disp_q     <= '0;
            comp_q     <= '0;
        end else begin
            in_state   <= in_state_nxt;
            in_sel     <= in_sel_nxt;
            in_rr      <= in_rr_nxt;
            out_sel    <= out_sel_nxt;
            out_rr     <= out_rr_nxt;
            out_locked <= out_locked_nxt;
            busy_q     <= busy_nxt;
            disp_q     <= disp_nxt;
            comp_q     <= comp_nxt;
        end
    end

endmodule

// File: tb/tb_tile_solver_dispatcher.sv
// Purpose: randomized host, solver and sink traffic around the dispatcher, compared each cycle with a transaction-level reference.
// Latency: outputs are sampled 1 time unit after the negedge that drives the inputs.
// Backpressure: random in_ready from solvers, random out_ready, random result withdrawals and random mid-traffic resets.
module tb_tile_solver_dispatcher;
    localparam int N  = 4;
    localparam int SB = 2;
    localparam int CYCLES = 5000;

    logic              clock, reset;
    logic [31:0]       in_data;
    logic              in_valid, in_ready, in_end_of_stream;
    logic [31:0]       out_addr;
    logic [15:0]       out_data;
    logic              out_valid, out_ready;
    logic [31:0]       slv_in_data;
    logic [N-1:0]      slv_in_valid, slv_in_ready, slv_in_end_of_stream;
    logic [32*N-1:0]   slv_out_addr;
    logic [16*N-1:0]   slv_out_data;
    logic [N-1:0]      slv_out_valid, slv_out_ready, busy;
    logic [15:0]       dispatched_count, completed_count;

    tile_solver_dispatcher #(.NUM_SOLVERS(N), .SEL_BITS(SB)) dut (
        .clock(clock), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_end_of_stream(in_end_of_stream),
        .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .slv_in_data(slv_in_data), .slv_in_valid(slv_in_valid), .slv_in_ready(slv_in_ready),
        .slv_in_end_of_stream(slv_in_end_of_stream),
        .slv_out_addr(slv_out_addr), .slv_out_data(slv_out_data),
        .slv_out_valid(slv_out_valid), .slv_out_ready(slv_out_ready),
        .busy(busy), .dispatched_count(dispatched_count), .completed_count(completed_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec, n_bad, cyc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // First index at or after 'from' (circularly) whose bit equals 'want'; -1 if none.
    function automatic int first_from(input logic [N-1:0] v, input bit want, input int from);
        for (int k = 0; k < N; k++) begin
            if (v[(from + k) % N] == want) return (from + k) % N;
        end
        return -1;
    endfunction

    // Host agent
    bit          h_vld, h_eos;
    logic [31:0] h_dat;
    int          h_len, h_idx;
    // Solver agents
    bit          s_got [N];
    bit          s_rv  [N];
    int          s_dly [N];
    logic [31:0] s_ra  [N];
    logic [15:0] s_rd  [N];
    // Reference model: which solvers hold packets, who is being fed, whose result is on the port
    logic [N-1:0] m_busy;
    int           m_in_rr, m_out_rr, m_isel, m_osel;
    bit           m_feeding, m_showing;
    logic [15:0]  m_disp, m_comp;
    int           total_disp, total_comp;

    logic [N-1:0] e_siv, e_seos, e_sor, nb;
    logic [31:0]  e_oa;
    logic [15:0]  e_od;
    bit           e_ov, e_ir;
    int           pick;

    initial begin
        n_vec = 0; n_bad = 0; total_disp = 0; total_comp = 0;
        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_end_of_stream = 1'b0;
        out_ready = 1'b0; slv_in_ready = '0; slv_out_addr = '0; slv_out_data = '0; slv_out_valid = '0;
        h_vld = 0; h_eos = 0; h_dat = '0; h_len = 3; h_idx = 0;
        for (int i = 0; i < N; i++) begin
            s_got[i] = 0; s_rv[i] = 0; s_dly[i] = 0; s_ra[i] = '0; s_rd[i] = '0;
        end
        m_busy = '0; m_in_rr = 0; m_out_rr = 0; m_isel = 0; m_osel = 0;
        m_feeding = 0; m_showing = 0; m_disp = '0; m_comp = '0;

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clock);
            // ---- drive stimulus ----
            reset = (cyc < 3) || ($urandom_range(0, 699) == 0);
            if (!h_vld && $urandom_range(0, 3) != 0) begin
                h_vld = 1;
                h_dat = $urandom;
                h_eos = (h_idx == h_len - 1);
            end
            in_valid         = h_vld;
            in_data          = h_vld ? h_dat : $urandom;
            in_end_of_stream = h_vld ? h_eos : 1'($urandom_range(0, 1));
            out_ready        = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                slv_in_ready[i] = ($urandom_range(0, 4) != 0);
                if (s_got[i] && !s_rv[i]) begin
                    if (s_dly[i] == 0) begin
                        s_rv[i] = 1;
                        s_ra[i] = $urandom;
                        s_rd[i] = 16'($urandom);
                    end else begin
                        s_dly[i]--;
                    end
                end
                slv_out_valid[i]       = s_rv[i] && ($urandom_range(0, 15) != 0);
                slv_out_addr[32*i +: 32] = s_rv[i] ? s_ra[i] : $urandom;
                slv_out_data[16*i +: 16] = s_rv[i] ? s_rd[i] : 16'($urandom);
            end
            #1;
            // ---- expected outputs from the reference ----
            e_ir = 0; e_siv = '0; e_seos = '0; e_sor = '0; e_ov = 0; e_oa = '0; e_od = '0;
            if (!reset) begin
                if (m_feeding) begin
                    e_ir           = slv_in_ready[m_isel];
                    e_siv[m_isel]  = in_valid;
                    e_seos[m_isel] = in_valid & in_end_of_stream;
                end
                if (m_showing) begin
                    e_ov          = slv_out_valid[m_osel];
                    e_oa          = slv_out_addr[32*m_osel +: 32];
                    e_od          = slv_out_data[16*m_osel +: 16];
                    e_sor[m_osel] = out_ready;
                end
            end
            check_val("in_ready",     64'(in_ready), 64'(e_ir));
            check_val("slv_in_valid", 64'(slv_in_valid), 64'(e_siv));
            check_val("slv_in_eos",   64'(slv_in_end_of_stream), 64'(e_seos));
            check_val("slv_in_data",  64'(slv_in_data), reset ? 64'd0 : 64'(in_data));
            check_val("out_valid",    64'(out_valid), 64'(e_ov));
            check_val("out_addr",     64'(out_addr), 64'(e_oa));
            check_val("out_data",     64'(out_data), 64'(e_od));
            check_val("slv_out_ready", 64'(slv_out_ready), 64'(e_sor));
            check_val("busy",         64'(busy), reset ? 64'd0 : 64'(m_busy));
            check_val("dispatched",   64'(dispatched_count), reset ? 64'd0 : 64'(m_disp));
            check_val("completed",    64'(completed_count), reset ? 64'd0 : 64'(m_comp));

            // ---- agents follow what the DUT actually did ----
            if (reset) begin
                h_vld = 0; h_idx = 0; h_len = $urandom_range(1, 4);
                for (int i = 0; i < N; i++) begin
                    s_got[i] = 0; s_rv[i] = 0;
                end
            end else begin
                if (in_valid && in_ready) begin
                    if (h_eos) begin
                        h_idx = 0;
                        h_len = $urandom_range(1, 4);
                    end else begin
                        h_idx++;
                    end
                    h_vld = 0;
                end
                for (int i = 0; i < N; i++) begin
                    if (slv_in_valid[i] && slv_in_ready[i] && slv_in_end_of_stream[i]) begin
                        s_got[i] = 1;
                        s_dly[i] = $urandom_range(0, 12);
                    end
                    if (slv_out_valid[i] && slv_out_ready[i]) begin
                        s_got[i] = 0;
                        s_rv[i]  = 0;
                    end
                end
            end

            // ---- reference model advances across the clock edge ----
            if (reset) begin
                m_busy = '0; m_in_rr = 0; m_out_rr = 0;
                m_feeding = 0; m_showing = 0; m_disp = '0; m_comp = '0;
            end else begin
                nb = m_busy;
                if (m_feeding) begin
                    if (in_valid && slv_in_ready[m_isel] && in_end_of_stream) begin
                        nb[m_isel] = 1'b1;
                        m_in_rr    = (m_isel + 1) % N;
                        m_disp     = m_disp + 16'd1;
                        total_disp++;
                        m_feeding  = 0;
                    end
                end else begin
                    pick = first_from(m_busy, 1'b0, m_in_rr);
                    if (pick >= 0) begin
                        m_isel    = pick;
                        m_feeding = 1;
                    end
                end
                if (m_showing) begin
                    if (!slv_out_valid[m_osel]) begin
                        m_showing = 0;
                    end else if (out_ready) begin
                        nb[m_osel] = 1'b0;
                        m_comp     = m_comp + 16'd1;
                        total_comp++;
                        m_out_rr   = (m_osel + 1) % N;
                        m_showing  = 0;
                    end
                end else begin
                    pick = first_from(slv_out_valid, 1'b1, m_out_rr);
                    if (pick >= 0) begin
                        m_osel    = pick;
                        m_showing = 1;
                    end
                end
                m_busy = nb;
            end
        end

        check_val("traffic_dispatched", 64'(total_disp > 200), 64'd1);
        check_val("traffic_completed",  64'(total_comp > 200), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/tile_solver_dispatcher.md
Name: tile_solver_dispatcher

Overview:
Scheduler that shares one input packet stream and one result stream across NUM_SOLVERS tile_solver_legit instances.
- Routes each complete input packet (words up to and including the in_end_of_stream word) to one idle solver, chosen round-robin.
- Arbitrates the solvers' (addr, iterations) results round-robin onto a single output port.
- Sits between the host packet interface and the solver array, so throughput scales with solver count.

Parameters:
NUM_SOLVERS, 4, number of attached solver instances (2..16)
SEL_BITS, 2, index width; must satisfy 2**SEL_BITS >= NUM_SOLVERS

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  32  host packet word
in_valid  in  1  host word valid
in_ready  out  1  dispatcher accepts word
in_end_of_stream  in  1  qualifies the last word of a packet
out_addr  out  32  selected result address
out_data  out  16  selected result iteration count
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
slv_in_data  out  32  broadcast copy of in_data
slv_in_valid  out  NUM_SOLVERS  per-solver word valid
slv_in_ready  in  NUM_SOLVERS  per-solver in_ready
slv_in_end_of_stream  out  NUM_SOLVERS  per-solver end-of-packet
slv_out_addr  in  32*NUM_SOLVERS  packed; solver i at bits [32i+31:32i]
slv_out_data  in  16*NUM_SOLVERS  packed; solver i at bits [16i+15:16i]
slv_out_valid  in  NUM_SOLVERS  per-solver result valid
slv_out_ready  out  NUM_SOLVERS  per-solver result accept
busy  out  NUM_SOLVERS  solver holds an unfinished packet
dispatched_count  out  16  packets dispatched (wraps)
completed_count  out  16  results delivered (wraps)

Behaviour:
- Reset state: busy=0, in_rr=0, out_rr=0, input FSM=SELECT, output unlocked, both counters=0. All outputs are 0 while in reset.
- Input FSM, SELECT:
  - in_ready=0; all slv_in_valid and slv_in_end_of_stream =0.
  - Scan from in_rr upward (modulo NUM_SOLVERS) for the first index with busy=0.
  - If one is found: register it as in_sel and go to FORWARD next cycle.
  - If none is found (all busy): stay in SELECT; host data must be held.
- Input FSM, FORWARD (zero-latency combinational passthrough to in_sel only):
  - in_ready = slv_in_ready[in_sel]
  - slv_in_valid[in_sel] = in_valid
  - slv_in_end_of_stream[in_sel] = in_end_of_stream & in_valid
  - All other lanes are 0. slv_in_data = in_data at all times.
- Packet end: on an accepted word (in_valid & in_ready) with in_end_of_stream=1:
  - busy[in_sel] <= 1
  - in_rr <= in_sel+1 (wrap to 0 at NUM_SOLVERS)
  - dispatched_count += 1
  - go to SELECT
- Minimum gap between packets is therefore one cycle (the SELECT cycle).
- in_end_of_stream without in_valid is ignored. in_valid during SELECT is not accepted.
- Output arbiter, unlocked:
  - out_valid=0; all slv_out_ready=0.
  - Scan slv_out_valid from out_rr (modulo NUM_SOLVERS). The first set index is registered as out_sel, and the arbiter locks next cycle.
- Output arbiter, locked:
  - out_addr/out_data/out_valid = slv_out_addr/slv_out_data/slv_out_valid of out_sel.
  - slv_out_ready[out_sel] = out_ready; all other slv_out_ready are 0.
  - While out_valid=1 and out_ready=0, outputs hold stable.
  - On out_valid & out_ready: busy[out_sel] <= 0, completed_count += 1, out_rr <= out_sel+1 (wrap), unlock.
  - If slv_out_valid[out_sel] drops while locked: unlock without side effects.
- Result latency: one cycle from a solver raising out_valid (arbiter idle) to out_valid.
- Busy set (input) and busy clear (output) in the same cycle always hit different indices, because a forwarded solver is never busy. Both updates apply.
- Counters wrap 0xFFFF -> 0x0000.
- Reset mid-packet or mid-result: the dispatcher returns to its reset state and the partial packet is discarded. The solvers share reset and likewise discard it.

Test Plan:
- Reset, then 4 packets (3 words each, EOS on the 3rd) with NUM_SOLVERS=4 -> routed to solvers 0,1,2,3 in order; busy=4'b1111; dispatched_count=4.
- All busy, 5th packet presented -> in_ready=0 until solver 2's result (addr=0x10, data=37) is accepted. The packet then goes to solver 2; out_addr=0x10, out_data=37; completed_count=1.
- Solvers 1 and 3 raise slv_out_valid in the same cycle with out_rr=0 -> solver 1 result emitted first, then solver 3; final out_rr=0.
- out_ready held 0 for 5 cycles while locked on solver 2 -> out_addr/out_data stable, slv_out_ready[2]=0, busy[2] stays 1; on out_ready=1 it clears after exactly one transfer.
- slv_in_ready[in_sel]=0 for 3 cycles mid-packet -> in_ready=0 and no word is lost; word order at the solver matches host order.
- reset asserted after word 2 of a packet -> next cycle busy=0, FSM=SELECT, counters=0; the next packet goes to solver 0.
